mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready front end for a registered word storage.
// Ports: req_* in, rsp_* out, mem_* storage side, wr_count/rd_count stats.
module mem_access_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic [15:0]      wr_count,
  output logic [15:0]      rd_count
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    RSP
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic [15:0]      rd_count_q, rd_count_d;

  logic idle;
  logic accept;
  logic in_range;
  logic cap_err;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;

    idle     = (state_q == IDLE);
    accept   = req_valid & idle;
    in_range = ({1'b0, req_addr} < DEPTH_W);
    cap_err  = ({1'b0, addr_q} >= DEPTH_W);

    req_ready = idle;
    rsp_valid = (state_q == RSP);

    // Enables are gated by rst_n so nothing strobes the storage in reset.
    mem_write_en = rst_n & accept & req_write & in_range;
    mem_read_en  = rst_n & accept & ~req_write & in_range;

    mem_addr    = idle ? req_addr : addr_q;
    mem_data_in = idle ? req_wdata : data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_write) begin
            if (in_range && wr_count_q != 16'hFFFF)
              wr_count_d = wr_count_q + 16'd1;
          end else begin
            addr_d  = req_addr;
            data_d  = req_wdata;
            state_d = RD_WAIT;
            if (rd_count_q != 16'hFFFF)
              rd_count_d = rd_count_q + 16'd1;
          end
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        // Out-of-range reads never touched storage; answer 0.
        rdata_d = cap_err ? '0 : mem_data_out;
        err_d   = cap_err;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed checks of mem_access_ctrl.
// DEPTH=12 so addresses 12..15 are out of range.
module tb_mem_access_ctrl;

  localparam int W = 8;
  localparam int D = 12;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [3:0]   req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic [3:0]   mem_addr;
  logic [W-1:0] mem_data_in;
  logic         mem_write_en;
  logic         mem_read_en;
  logic [W-1:0] mem_data_out;
  logic [15:0]  wr_count;
  logic [15:0]  rd_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] ref_mem [D];
  int           exp_wr = 0;
  int           exp_rd = 0;

  // storage behind the controller
  logic [W-1:0] store [16];

  mem_access_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) store[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= store[mem_addr];
  end

  // Call just after a negedge with no request outstanding.
  task automatic do_write(input int a, input logic [W-1:0] d);
    bit inr;
    inr = (a < D);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'(a);
    req_wdata = d;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready a=%0d got %b want 1", a, req_ready);
    end
    checks++;
    if (mem_write_en !== inr) begin
      errors++;
      $display("FAIL wr_en a=%0d got %b want %b", a, mem_write_en, inr);
    end
    if (inr) begin
      checks++;
      if (mem_addr !== 4'(a) || mem_data_in !== d) begin
        errors++;
        $display("FAIL wr_bus got %h/%h want %h/%h",
                 mem_addr, mem_data_in, 4'(a), d);
      end
    end
    @(posedge clk);
    if (inr) begin
      ref_mem[a] = d;
      if (exp_wr < 65535) exp_wr++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL wr_count got %0d want %0d", wr_count, exp_wr);
    end
  endtask

  task automatic do_read(input int a, input int hold);
    bit           inr;
    logic [W-1:0] er;
    inr = (a < D);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'(a);
    req_wdata = 8'($urandom);
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_read_en !== inr) begin
      errors++;
      $display("FAIL rd_accept a=%0d got rdy=%b ren=%b want 1/%b",
               a, req_ready, mem_read_en, inr);
    end
    @(posedge clk);
    er = inr ? ref_mem[a] : '0;
    if (exp_rd < 65535) exp_rd++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_read_en !== 1'b0
        || rd_count !== 16'(exp_rd)) begin
      errors++;
      $display("FAIL rd_wait got rdy=%b v=%b ren=%b cnt=%0d want 0/0/0/%0d",
               req_ready, rsp_valid, mem_read_en, rd_count, exp_rd);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mem_read_en !== 1'b0) begin
      errors++;
      $display("FAIL rd_early got v=%b ren=%b want 0/0",
               rsp_valid, mem_read_en);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== !inr) begin
      errors++;
      $display("FAIL rd_rsp a=%0d got v=%b d=%h e=%b want 1/%h/%b",
               a, rsp_valid, rsp_rdata, rsp_err, er, !inr);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== !inr
          || req_ready !== 1'b0 || mem_write_en !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold i=%0d got v=%b d=%h e=%b rdy=%b we=%b",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_write_en);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_done got v=%b rdy=%b want 0/1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 8'h5A;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_write_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0
        || rsp_rdata !== '0 || wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_wr got we=%b v=%b e=%b d=%h wc=%0d rc=%0d",
               mem_write_en, rsp_valid, rsp_err, rsp_rdata,
               wr_count, rd_count);
    end
    req_write = 1'b0;
    #1;
    checks++;
    if (mem_read_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd got ren=%b want 0", mem_read_en);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel got rdy=%b v=%b want 1/0",
               req_ready, rsp_valid);
    end
    exp_wr = 0;
    exp_rd = 0;
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++)
      do_write(a, 8'($urandom));
    checks++;
    if (wr_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", wr_count);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < D; a++)
      do_write(a, 8'($urandom));
  endtask

  task automatic test_write_read();
    do_write(3, 8'hA5);
    do_read(3, 0);
    checks++;
    if (rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_a5 got %h/%b want a5/0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_rsp_stall();
    do_write(7, 8'h3C);
    do_read(7, 5);
  endtask

  task automatic test_out_of_range();
    int wc;
    wc = exp_wr;
    do_write(13, 8'hFF);
    checks++;
    if (wr_count !== 16'(wc)) begin
      errors++;
      $display("FAIL oor_wr got %0d want %0d", wr_count, wc);
    end
    do_read(13, 2);
    do_read(12, 0);
    do_read(11, 1);
  endtask

  task automatic test_reset_mid_read();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || wr_count !== 16'd0 || rd_count !== 16'd0
        || rsp_rdata !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got v=%b wc=%0d rc=%0d d=%h rdy=%b",
               rsp_valid, wr_count, rd_count, rsp_rdata, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr = 0;
    exp_rd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_stale i=%0d got v=%b rdy=%b want 0/1",
                 i, rsp_valid, req_ready);
      end
    end
    do_read(5, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL idle_rsp_ready got v=%b rdy=%b want 0/1",
                   rsp_valid, req_ready);
        end
      end
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, 15)), 8'($urandom));
      else
        do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    exp_wr = 65534;
    do_write(1, 8'h11);
    do_write(2, 8'h22);
    do_write(14, 8'h33);
    do_write(4, 8'h44);
    checks++;
    if (wr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final got %h want ffff", wr_count);
    end
    do_read(2, 0);
  endtask

  initial begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    test_reset();
    test_back_to_back();
    test_fill();
    test_write_read();
    test_rsp_stall();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
